// File: rtl/comparator_pkg.sv
// Shared encodings for the serial magnitude comparator: FSM states and one-hot {e,g,l} results.
package comparator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] CMP_EQ = 3'b100;
    localparam logic [2:0] CMP_GT = 3'b010;
    localparam logic [2:0] CMP_LT = 3'b001;

endpackage

// File: rtl/comparator_2bit_slice.sv
// Combinational 2-bit unsigned magnitude slice; exactly one of e/g/l is high.
module comparator_2bit_slice (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic       e,
    output logic       g,
    output logic       l
);

    assign e = (a == b);
    assign g = (a > b);
    assign l = (a < b);

endmodule

// File: rtl/comparator_serial_nbit.sv
// Serial N-bit comparator, two bits per cycle MSB first; result valid from the done pulse.
// COMPARE_EARLY_EXIT_EN: finish on the first differing slice instead of always running SLICES cycles.
module comparator_serial_nbit
    import comparator_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             e,
    output logic             g,
    output logic             l
);

    localparam int SLICES = WIDTH / 2;
    localparam int IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IDX_W-1:0] idx;
    logic [2:0]       flags;
    logic [1:0]       slice_a;
    logic [1:0]       slice_b;
    logic             s_e;
    logic             s_g;
    logic             s_l;
    logic             accept;
    logic             finish;
    logic             decided;

    assign slice_a = 2'(a_q >> {idx, 1'b0});
    assign slice_b = 2'(b_q >> {idx, 1'b0});

    comparator_2bit_slice u_slice (
        .a (slice_a),
        .b (slice_b),
        .e (s_e),
        .g (s_g),
        .l (s_l)
    );

    assign accept = start && (state != RUN);

`ifdef COMPARE_EARLY_EXIT_EN
    assign decided = 1'b0;
    assign finish  = s_g || s_l || (idx == '0);
`else
    // Sticky: once a slice differs, later slices must not touch the flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            decided <= 1'b0;
        end else if (accept) begin
            decided <= 1'b0;
        end else if (state == RUN && (s_g || s_l)) begin
            decided <= 1'b1;
        end
    end
    assign finish = (idx == '0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (finish) state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            idx   <= '0;
            flags <= '0;
        end else if (accept) begin
            a_q   <= a;
            b_q   <= b;
            idx   <= IDX_W'(SLICES - 1);
            flags <= '0;
        end else if (state == RUN) begin
            if (!decided && (s_g || s_l)) begin
                flags <= s_g ? CMP_GT : CMP_LT;
            end else if (!decided && s_e && idx == '0) begin
                flags <= CMP_EQ;
            end
            if (!finish) begin
                idx <= idx - 1'b1;
            end
        end
    end

    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign {e, g, l} = flags;

endmodule
